mul_div_unit: RTL and testbench

Iterative 24-bit unsigned multiply/divide unit sitting beside the ALU in the execute path. It consumes the two register-file read ports (RS/RT operands) and produces a write-back result, destination index and write strobe for the register file. Multi-cycle: the control unit stalls the PC while Busy is high.

---
 rtl/mul_div_unit.sv | 118 +++++++++++
 tb/tb_mul_div_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit for the execute stage.
// Shift-add multiply or restoring divide, one bit per clock, with register-file write-back.
module mul_div_unit #(
  parameter int WIDTH = 24,
  parameter int AW    = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic [AW-1:0]    DestIn,
  output logic             Busy,
  output logic             Done,
  output logic             RegwriteOut,
  output logic [AW-1:0]    DestOut,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             op_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] addend_q;   // multiplicand or divisor
  logic [WIDTH-1:0] hi_q;       // product high half / partial remainder
  logic [WIDTH-1:0] lo_q;       // multiplier -> product low / dividend -> quotient
  logic [AW-1:0]    dest_q;
  logic             dbz_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] hi_step;
  logic [WIDTH-1:0] lo_step;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One iteration of either algorithm; both leave low/quotient in lo_q and high/remainder in hi_q.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, addend_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, addend_q};
    div_diff  = div_shift[WIDTH-1:0] - addend_q;
    if (op_q) begin
      hi_step = div_ge ? div_diff : div_shift[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      hi_step = mul_sum[WIDTH:1];
      lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // NOTE: datapath registers are reset too, because reset must clear every visible output.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      op_q     <= 1'b0;
      cnt_q    <= '0;
      addend_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dest_q   <= '0;
      dbz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            op_q     <= Op;
            dest_q   <= DestIn;
            cnt_q    <= '0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= Op ? OperandA : OperandB;
            addend_q <= Op ? OperandB : OperandA;
          end
        end
        RUN: begin
          hi_q  <= hi_step;
          lo_q  <= lo_step;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) dbz_q <= op_q && (addend_q == '0);
        end
        default: ;
      endcase
    end
  end

  assign Busy        = (state_q != IDLE);
  assign Done        = (state_q == DONE);
  assign RegwriteOut = (state_q == DONE);
  assign DestOut     = dest_q;
  assign Result      = lo_q;
  assign ResultHi    = hi_q;
  assign DivByZero   = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random operations
// compared with a plain-arithmetic reference model.
module tb_mul_div_unit;

  localparam int WIDTH = 24;
  localparam int AW    = 4;

  logic             Clock = 1'b0;
  logic             Reset = 1'b0;
  logic             Start = 1'b0;
  logic             Op = 1'b0;
  logic [WIDTH-1:0] OperandA = '0;
  logic [WIDTH-1:0] OperandB = '0;
  logic [AW-1:0]    DestIn = '0;
  logic             Busy, Done, RegwriteOut, DivByZero;
  logic [AW-1:0]    DestOut;
  logic [WIDTH-1:0] Result, ResultHi;

  int tests = 0;
  int failures = 0;

  mul_div_unit #(.WIDTH(WIDTH), .AW(AW)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB), .DestIn(DestIn),
    .Busy(Busy), .Done(Done), .RegwriteOut(RegwriteOut), .DestOut(DestOut),
    .Result(Result), .ResultHi(ResultHi), .DivByZero(DivByZero)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({Busy, Done, RegwriteOut, DivByZero, DestOut, Result, ResultHi});
  endfunction

  // Reference model: unsigned arithmetic straight from the operation rules.
  task automatic model(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       output logic [WIDTH-1:0] lo, output logic [WIDTH-1:0] hi, output logic dbz);
    logic [2*WIDTH-1:0] prod;
    if (!op) begin
      prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      lo = prod[WIDTH-1:0];
      hi = prod[2*WIDTH-1:WIDTH];
      dbz = 1'b0;
    end else if (b == '0) begin
      lo = '1;
      hi = a;
      dbz = 1'b1;
    end else begin
      lo = a / b;
      hi = a % b;
      dbz = 1'b0;
    end
  endtask

  task automatic run_op(input string tag, input logic op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [AW-1:0] dest);
    logic [WIDTH-1:0] exp_lo, exp_hi;
    logic exp_dbz;
    int n;
    bit busy_gap;
    model(op, a, b, exp_lo, exp_hi, exp_dbz);
    @(negedge Clock);
    Start = 1'b1; Op = op; OperandA = a; OperandB = b; DestIn = dest;
    @(posedge Clock);  // E0
    #1;
    Start = 1'b0;
    OperandA = WIDTH'($urandom); OperandB = WIDTH'($urandom); DestIn = AW'($urandom);
    check({tag, "_busy_rise"}, 64'(Busy), 64'd1);
    n = 0;
    busy_gap = 1'b0;
    while (!Done && n < 40) begin
      @(posedge Clock);
      #1;
      n++;
      if (!Busy) busy_gap = 1'b1;
    end
    check({tag, "_latency"}, 64'(n), 64'(WIDTH));
    check({tag, "_busy_contig"}, 64'(busy_gap), 64'd0);
    check({tag, "_regwrite"}, 64'(RegwriteOut), 64'd1);
    check({tag, "_dest"}, 64'(DestOut), 64'(dest));
    check({tag, "_result"}, 64'(Result), 64'(exp_lo));
    check({tag, "_result_hi"}, 64'(ResultHi), 64'(exp_hi));
    check({tag, "_dbz"}, 64'(DivByZero), 64'(exp_dbz));
    @(posedge Clock);
    #1;
    check({tag, "_after_done"}, 64'({Done, RegwriteOut, Busy}), 64'd0);
    check({tag, "_hold"}, 64'({Result, ResultHi}), 64'({exp_lo, exp_hi}));
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic [WIDTH-1:0] first_lo, first_hi;
    logic             first_dbz;
    int               n;
    bit               saw_done, busy_gap;

    // Reset state
    repeat (3) @(posedge Clock);
    #1;
    check("reset_outputs", all_outputs(), 64'd0);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    check("idle_after_reset", all_outputs(), 64'd0);

    // Directed cases
    run_op("mul_small", 1'b0, 24'h0004D2, 24'h00000A, 4'd5);
    check("mul_small_const", 64'({ResultHi, Result}), 64'({24'h000000, 24'h003034}));
    run_op("mul_max", 1'b0, 24'hFFFFFF, 24'hFFFFFF, 4'd15);
    check("mul_max_const", 64'({ResultHi, Result}), 64'({24'hFFFFFE, 24'h000001}));
    run_op("div_100_7", 1'b1, 24'd100, 24'd7, 4'd3);
    check("div_100_7_const", 64'({DivByZero, ResultHi, Result}), 64'({1'b0, 24'd2, 24'd14}));
    run_op("div_zero", 1'b1, 24'h00ABCD, 24'h000000, 4'd7);
    check("div_zero_const", 64'({DivByZero, ResultHi, Result}), 64'({1'b1, 24'h00ABCD, 24'hFFFFFF}));
    run_op("div_clears_dbz", 1'b1, 24'hFFFFFF, 24'h000001, 4'd1);
    run_op("div_small_by_big", 1'b1, 24'h000010, 24'hFFFFFF, 4'd2);

    // Start pulses during RUN and DONE are ignored
    model(1'b0, 24'h123456, 24'h000ABC, first_lo, first_hi, first_dbz);
    @(negedge Clock);
    Start = 1'b1; Op = 1'b0; OperandA = 24'h123456; OperandB = 24'h000ABC; DestIn = 4'd9;
    @(posedge Clock);  // E0
    #1;
    Start = 1'b0;
    n = 0;
    busy_gap = 1'b0;
    while (!Done && n < 40) begin
      if (n == 4) begin
        Start = 1'b1; Op = 1'b1; OperandA = 24'h000777; OperandB = 24'h000003; DestIn = 4'd2;
      end
      @(posedge Clock);
      #1;
      n++;
      if (n == 5) Start = 1'b0;
      if (!Busy) busy_gap = 1'b1;
    end
    check("ign_latency", 64'(n), 64'(WIDTH));
    check("ign_busy_contig", 64'(busy_gap), 64'd0);
    check("ign_result", 64'({DestOut, ResultHi, Result}), 64'({4'd9, first_hi, first_lo}));
    Start = 1'b1; Op = 1'b0; OperandA = 24'h000002; OperandB = 24'h000002; DestIn = 4'd4;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    check("ign_done_start", 64'({Busy, Done}), 64'd0);
    repeat (3) @(posedge Clock);
    #1;
    check("ign_hold", 64'({Busy, DestOut, ResultHi, Result}), 64'({1'b0, 4'd9, first_hi, first_lo}));

    // Asynchronous reset in mid-multiply
    @(negedge Clock);
    Start = 1'b1; Op = 1'b0; OperandA = 24'h00F00F; OperandB = 24'h000123; DestIn = 4'd6;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    repeat (10) @(posedge Clock);
    #1;
    Reset = 1'b0;
    #1;
    check("async_reset_outputs", all_outputs(), 64'd0);
    @(negedge Clock);
    Reset = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge Clock);
      #1;
      if (Done || Busy) saw_done = 1'b1;
    end
    check("no_done_after_reset", 64'(saw_done), 64'd0);
    run_op("mul_3x5", 1'b0, 24'd3, 24'd5, 4'd8);
    check("mul_3x5_const", 64'(Result), 64'd15);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = WIDTH'($urandom_range(1, 15));
        default: rb = WIDTH'($urandom);
      endcase
      if (i % 5 == 4) ra = ra >> $urandom_range(0, WIDTH - 1);
      run_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), ra, rb, AW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
